// File: rtl/ysyx_22041752_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in a single cycle.
module ysyx_22041752_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic            op_word,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] div_result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [XLEN-1:0]   rem_reg, quo_reg, dsr_reg, result_reg;
  logic              rem_flag_reg, word_reg, q_neg_reg, a_neg_reg;

  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_neg, special_raw;
  logic              a_neg, b_neg, div_zero, overflow, special, accept;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_it, quo_it, q_signed, r_signed, calc_raw;

  // W results are always the sign-extension of the low half, even for unsigned ops
  function automatic logic [XLEN-1:0] fit(input logic word, input logic [XLEN-1:0] v);
    fit = word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  always_comb begin
    if (op_word) begin
      a_ext   = op_signed ? {{HALF{div_src1[HALF-1]}}, div_src1[HALF-1:0]}
                          : {{HALF{1'b0}}, div_src1[HALF-1:0]};
      b_ext   = op_signed ? {{HALF{div_src2[HALF-1]}}, div_src2[HALF-1:0]}
                          : {{HALF{1'b0}}, div_src2[HALF-1:0]};
      min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_ext   = div_src1;
      b_ext   = div_src2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg       = op_signed & a_ext[XLEN-1];
    b_neg       = op_signed & b_ext[XLEN-1];
    a_mag       = a_neg ? -a_ext : a_ext;
    b_mag       = b_neg ? -b_ext : b_ext;
    div_zero    = (b_ext == '0);
    overflow    = op_signed && (a_ext == min_neg) && (b_ext == {XLEN{1'b1}});
    special     = div_zero | overflow;
    special_raw = div_zero ? (op_rem ? a_ext : {XLEN{1'b1}})
                           : (op_rem ? '0 : a_ext);
  end

  // One restoring step: the extra top bit of diff is the borrow
  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    diff     = shifted - {1'b0, dsr_reg};
    rem_it   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_it   = {quo_reg[XLEN-2:0], ~diff[XLEN]};
    q_signed = q_neg_reg ? -quo_it : quo_it;
    r_signed = a_neg_reg ? -rem_it : rem_it;
    calc_raw = rem_flag_reg ? r_signed : q_signed;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    div_ready    = (state_reg == IDLE);
    result_valid = (state_reg == DONE);
    accept       = (state_reg == IDLE) && div_valid && !flush;
    case (state_reg)
      IDLE:    if (div_valid) state_next = special ? DONE : CALC;
      CALC:    if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dsr_reg      <= '0;
      result_reg   <= '0;
      rem_flag_reg <= 1'b0;
      word_reg     <= 1'b0;
      q_neg_reg    <= 1'b0;
      a_neg_reg    <= 1'b0;
    end else if (accept) begin
      rem_flag_reg <= op_rem;
      word_reg     <= op_word;
      q_neg_reg    <= a_neg ^ b_neg;
      a_neg_reg    <= a_neg;
      dsr_reg      <= b_mag;
      rem_reg      <= '0;
      // W dividends sit in the upper half so the MSB-first shift sees them after HALF steps
      quo_reg      <= op_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
      cnt_reg      <= op_word ? CW'(HALF) : CW'(XLEN);
      if (special) result_reg <= fit(op_word, special_raw);
    end else if (state_reg == CALC && !flush) begin
      rem_reg <= rem_it;
      quo_reg <= quo_it;
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) result_reg <= fit(word_reg, calc_raw);
    end
  end

  assign div_result = result_reg;

endmodule

// File: tb/tb_ysyx_22041752_divider.sv
// Scoreboard bench for the iterative divider: directed cases, flush/reset, random back-to-back.
module tb_ysyx_22041752_divider;

  logic        clk = 1'b0;
  logic        reset, flush, div_valid, div_ready;
  logic        op_signed, op_rem, op_word;
  logic [63:0] div_src1, div_src2, div_result;
  logic        result_valid, result_ready;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_22041752_divider #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .div_valid(div_valid), .div_ready(div_ready),
    .op_signed(op_signed), .op_rem(op_rem), .op_word(op_word),
    .div_src1(div_src1), .div_src2(div_src2),
    .result_valid(result_valid), .result_ready(result_ready),
    .div_result(div_result)
  );

  // Presents one request for a single cycle, then scrambles the inputs to prove they were latched.
  task automatic issue(input logic s, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    exp_q.push_back(e);
    op_signed = s; op_rem = r; op_word = w;
    div_src1 = a; div_src2 = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    op_signed = ~s; op_rem = ~r; op_word = ~w;
    div_src1 = {$urandom, $urandom}; div_src2 = {$urandom, $urandom};
  endtask

  // Waits (bounded) for result_valid; lat counts cycles from accept, 1 = next cycle.
  task automatic collect(output logic seen, output int lat,
                         output logic [63:0] got, output logic [63:0] e);
    lat = 1;
    while (result_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    seen = (result_valid === 1'b1);
    got  = div_result;
    e    = 64'h0BAD_0BAD_0BAD_0BAD;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic ack();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  function automatic logic [63:0] model(input logic s, input logic r, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0)                                      r32 = r ? a32 : 32'hFFFF_FFFF;
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'd0 : a32;
      else if (s) r32 = r ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
      else        r32 = r ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0)                                            r64 = r ? a : '1;
    else if (s && a == 64'h8000_0000_0000_0000 && b == '1)      r64 = r ? 64'd0 : a;
    else if (s) r64 = r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    else        r64 = r ? a % b : a / b;
    return r64;
  endfunction

  task automatic test_reset();
    total++;
    if (div_ready !== 1'b1 || result_valid !== 1'b0 || div_result !== 64'd0) begin
      bad++;
      $display("FAIL reset ready=%b valid=%b result=%h required 1/0/0", div_ready, result_valid, div_result);
    end
  endtask

  task automatic test_unsigned();
    logic seen; int lat; logic [63:0] got, e;
    issue(1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14);
    collect(seen, lat, got, e);
    total++;
    if (!seen || got !== e) begin bad++; $display("FAIL divu_q got=%h exp=%h valid=%b", got, e, seen); end
    total++;
    if (lat != 65) begin bad++; $display("FAIL divu_latency got=%0d exp=65", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (result_valid !== 1'b1 || div_result !== 64'd14 || div_ready !== 1'b0) begin
        bad++;
        $display("FAIL divu_hold[%0d] valid=%b result=%h ready=%b exp 1/%h/0", i, result_valid, div_result, div_ready, 64'd14);
      end
    end
    ack();
    total++;
    if (result_valid !== 1'b0 || div_ready !== 1'b1) begin
      bad++; $display("FAIL divu_release valid=%b ready=%b exp 0/1", result_valid, div_ready);
    end
    issue(1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 64'd2);
    collect(seen, lat, got, e);
    total++;
    if (!seen || got !== e) begin bad++; $display("FAIL remu got=%h exp=%h valid=%b", got, e, seen); end
    ack();
  endtask

  task automatic test_signed();
    logic seen; int lat; logic [63:0] got, e;
    logic [2:0]  tf [4];
    logic [63:0] ta [4];
    logic [63:0] tbv[4];
    logic [63:0] te [4];
    tf  = '{3'b100, 3'b110, 3'b100, 3'b110};
    ta  = '{-64'sd7, -64'sd7, 64'd7, 64'd7};
    tbv = '{64'd2, 64'd2, -64'sd2, -64'sd2};
    te  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    for (int i = 0; i < 4; i++) begin
      issue(tf[i][2], tf[i][1], tf[i][0], ta[i], tbv[i], te[i]);
      collect(seen, lat, got, e);
      total++;
      if (!seen || got !== e) begin bad++; $display("FAIL signed[%0d] got=%h exp=%h valid=%b", i, got, e, seen); end
      total++;
      if (lat != 65) begin bad++; $display("FAIL signed_latency[%0d] got=%0d exp=65", i, lat); end
      ack();
    end
  endtask

  task automatic test_special();
    logic seen; int lat; logic [63:0] got, e;
    logic [2:0]  tf [8];
    logic [63:0] ta [8];
    logic [63:0] tbv[8];
    logic [63:0] te [8];
    tf  = '{3'b000, 3'b010, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111};
    ta  = '{64'h1234, 64'h1234, 64'hABCD_0000_0000_0005, 64'hABCD_0000_0000_0005,
            64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000};
    tbv = '{64'd0, 64'd0, 64'd0, 64'd0, '1, '1, '1, '1};
    te  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
            64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0};
    for (int i = 0; i < 8; i++) begin
      issue(tf[i][2], tf[i][1], tf[i][0], ta[i], tbv[i], te[i]);
      collect(seen, lat, got, e);
      total++;
      if (!seen || got !== e) begin bad++; $display("FAIL special[%0d] got=%h exp=%h valid=%b", i, got, e, seen); end
      total++;
      if (lat != 1) begin bad++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
      ack();
    end
  endtask

  task automatic test_word();
    logic seen; int lat; logic [63:0] got, e;
    logic [2:0]  tf [5];
    logic [63:0] ta [5];
    logic [63:0] tbv[5];
    logic [63:0] te [5];
    tf  = '{3'b001, 3'b011, 3'b001, 3'b101, 3'b111};
    ta  = '{64'hDEAD_BEEF_FFFF_FFFE, 64'h0000_0000_FFFF_FFFF, 64'h1111_2222_FFFF_FFFF,
            64'h0000_0000_FFFF_FF9C, 64'h0000_0000_FFFF_FF9C};
    tbv = '{64'd2, 64'h10, 64'hFFFF_0000_0000_0001, 64'd7, 64'd7};
    te  = '{64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE};
    for (int i = 0; i < 5; i++) begin
      issue(tf[i][2], tf[i][1], tf[i][0], ta[i], tbv[i], te[i]);
      collect(seen, lat, got, e);
      total++;
      if (!seen || got !== e) begin bad++; $display("FAIL word[%0d] got=%h exp=%h valid=%b", i, got, e, seen); end
      total++;
      if (lat != 33) begin bad++; $display("FAIL word_latency[%0d] got=%0d exp=33", i, lat); end
      ack();
    end
  endtask

  task automatic test_flush();
    logic seen; int lat; logic [63:0] got, e;
    logic rose;
    op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    div_src1 = 64'd1000; div_src2 = 64'd3; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (div_ready !== 1'b1 || result_valid !== 1'b0) begin
      bad++; $display("FAIL flush_calc ready=%b valid=%b exp 1/0", div_ready, result_valid);
    end
    rose = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) rose = 1'b1;
    end
    total++;
    if (rose !== 1'b0) begin bad++; $display("FAIL flush_no_result rose=%b exp 0", rose); end
    issue(1'b0, 1'b0, 1'b0, 64'd9, 64'd3, 64'd3);
    collect(seen, lat, got, e);
    total++;
    if (!seen || got !== e || lat != 65) begin
      bad++; $display("FAIL flush_after got=%h exp=%h lat=%0d exp_lat=65", got, e, lat);
    end
    ack();
    // request in a flush cycle is dropped
    div_src1 = 64'd5; div_src2 = 64'd0; div_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    total++;
    if (result_valid !== 1'b0 || div_ready !== 1'b1) begin
      bad++; $display("FAIL flush_accept valid=%b ready=%b exp 0/1", result_valid, div_ready);
    end
    // flush in DONE without result_ready
    issue(1'b0, 1'b0, 1'b0, 64'd5, 64'd0, '1);
    collect(seen, lat, got, e);
    total++;
    if (!seen || got !== e) begin bad++; $display("FAIL flush_done_pre got=%h exp=%h", got, e); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (result_valid !== 1'b0 || div_ready !== 1'b1) begin
      bad++; $display("FAIL flush_done valid=%b ready=%b exp 0/1", result_valid, div_ready);
    end
  endtask

  task automatic test_reset_done();
    logic seen; int lat; logic [63:0] got, e;
    issue(1'b0, 1'b1, 1'b0, 64'h1234, 64'd0, 64'h1234);
    collect(seen, lat, got, e);
    total++;
    if (!seen || got !== e) begin bad++; $display("FAIL reset_done_pre got=%h exp=%h", got, e); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (result_valid !== 1'b0 || div_result !== 64'd0 || div_ready !== 1'b1) begin
      bad++; $display("FAIL reset_done valid=%b result=%h ready=%b exp 0/0/1", result_valid, div_result, div_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic seen; int lat; logic [63:0] got, e, a, b;
    logic s, r, w;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 60);
      if (i == 0) b = 64'd0;
      total++;
      if (div_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, div_ready); end
      issue(s, r, w, a, b, model(s, r, w, a, b));
      collect(seen, lat, got, e);
      total++;
      if (!seen || got !== e) begin
        bad++; $display("FAIL b2b[%0d] s=%b r=%b w=%b a=%h b=%h got=%h exp=%h", i, s, r, w, a, b, got, e);
      end
      ack();
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; div_valid = 1'b0; result_ready = 1'b0;
    op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    div_src1 = '0; div_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_word();
    test_flush();
    test_reset_done();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
